rr_burst_arb: RTL and testbench
===============================

RR_BURST_ARB -- requirements
Module: rr_burst_arb

Interface
REQ-001 SHALL have parameter CNT, default 5: number of requesters; legal range 1..32.
REQ-002 SHALL have parameter MAX_BEATS, default 16: maximum beats per grant before forced release; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port req, input, CNT bits: per-requester request, held high for the whole burst.
REQ-006 SHALL have port last, input, CNT bits: per-requester end-of-burst marker, sampled only for the granted requester.
REQ-007 SHALL have port ready, input, 1 bit: downstream can accept a beat this cycle.
REQ-008 SHALL have port gnt, output, CNT bits: registered one-hot grant; drives the sel input of the downstream registered one-hot mux.
REQ-009 SHALL have port gnt_vld, output, 1 bit: registered; equals |gnt.
REQ-010 SHALL have port gnt_idx, output, max(1,clog2(CNT)) bits: registered binary index of the granted requester; 0 when gnt_vld=0.
REQ-011 SHALL have port beat, output, 1 bit: combinational, gnt_vld & ready & req[gnt_idx].
REQ-012 SHALL have port err_drop, output, 1 bit: registered one-cycle pulse when the granted requester drops req without last.
REQ-013 SHALL have port err_timeout, output, 1 bit: registered one-cycle pulse on forced release at MAX_BEATS.

Function
REQ-014 SHALL implement two states: IDLE (gnt_vld=0) and BUSY (gnt_vld=1).
REQ-015 SHALL keep a priority pointer ptr (0..CNT-1); the winner is the first set bit of req scanning ptr, ptr+1, ... and wrapping modulo CNT.
REQ-016 IDLE with |req=1 SHALL load gnt/gnt_idx with the winner on the next edge and enter BUSY; request-to-grant latency is 1 cycle.
REQ-017 IDLE with req=0 SHALL hold all state.
REQ-018 BUSY SHALL hold gnt, gnt_idx and ptr constant until a release event.
REQ-019 A release event SHALL occur on any of:
- (a) beat & last[gnt_idx];
- (b) req[gnt_idx]=0 (drop);
- (c) beat while beat_cnt = MAX_BEATS-1 and last[gnt_idx]=0 (timeout).
REQ-020 On release, ptr SHALL become (gnt_idx+1) mod CNT in the same edge.
REQ-021 On release, the next winner SHALL be arbitrated in the same edge using the new ptr and the current req; if one exists, gnt loads it with no bubble cycle and the state stays BUSY, otherwise gnt=0 and the state goes to IDLE.
REQ-022 The released requester SHALL be considered at lowest priority during the re-arbitration of REQ-021; it can win again only if it is the sole requester.
REQ-023 beat_cnt SHALL increment on each beat without release and SHALL clear to 0 on any release or grant load.
REQ-024 If a drop (REQ-019b) coincides with a timeout beat, err_drop SHALL win and err_timeout SHALL stay 0.
REQ-025 err_drop SHALL pulse for exactly one cycle on a drop release; err_timeout SHALL pulse for exactly one cycle on a timeout release.
REQ-026 Changes on req or last of non-granted requesters SHALL NOT affect gnt while BUSY.
REQ-027 gnt SHALL never have more than one bit set.
REQ-028 With CNT=1, ptr SHALL be constant 0 and gnt_idx SHALL be constant 0.

Reset
REQ-029 While rst_n=0, the following SHALL be asynchronously forced: gnt=0, gnt_vld=0, gnt_idx=0, ptr=0, beat_cnt=0, err_drop=0, err_timeout=0, state=IDLE.
REQ-030 A reset asserted mid-burst SHALL abandon the burst with no error pulse; after rst_n rises, the first arbitration SHALL start from ptr=0.

Verification
REQ-031 CNT=5, req=5'b10100 after reset, ready=1, last on the 3rd beat -> gnt=5'b00100 one cycle later; three beats; then gnt=5'b10000 with no bubble; ptr=3.
REQ-032 req=5'b11111 held, every beat has last -> grants rotate 0,1,2,3,4,0 on consecutive cycles.
REQ-033 Single requester 2, three one-beat bursts -> gnt=5'b00100 held continuously, ptr=3 after the first release.
REQ-034 MAX_BEATS=4, requester 1 never asserts last, ready=1 -> release after the 4th beat, err_timeout pulses once, beat_cnt returns to 0.
REQ-035 Requester 3 granted drops req with ready=0 -> err_drop pulse, gnt moves to the next requester or goes to 0; no err_timeout.
REQ-036 rst_n pulsed low during a BUSY burst -> all outputs 0 immediately; after release of reset, req=5'b00010 yields gnt=5'b00010 one cycle later.

Source files
------------

// File: rtl/rr_burst_arb.sv
// Round-robin burst arbiter: grants one requester at a time for a multi-beat
// burst, releases on last / drop / beat-count timeout, and re-arbitrates in
// the same edge so back-to-back bursts have no bubble cycle.
module rr_burst_arb #(
    parameter int CNT       = 5,
    parameter int MAX_BEATS = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [CNT-1:0]                      req,
    input  logic [CNT-1:0]                      last,
    input  logic                                ready,
    output logic [CNT-1:0]                      gnt,
    output logic                                gnt_vld,
    output logic [(CNT > 1 ? $clog2(CNT) : 1)-1:0] gnt_idx,
    output logic                                beat,
    output logic                                err_drop,
    output logic                                err_timeout
);

    localparam int IW = (CNT > 1) ? $clog2(CNT) : 1;
    localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int PW = 2 ** IW;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [BW-1:0]   beat_cnt;

    logic [PW-1:0]   req_pad;
    logic [PW-1:0]   last_pad;
    logic            cur_req;
    logic            cur_last;
    logic            at_max;
    logic            drop_ev;
    logic            done_ev;
    logic            to_ev;
    logic            rel;
    logic [IW-1:0]   rel_ptr;
    logic [IW-1:0]   scan_base;
    logic            found;
    logic [IW-1:0]   win;
    logic [CNT-1:0]  win_oh;

    // Release detection for the current grant and the next-pointer value.
    always_comb begin
        int unsigned nxt;
        req_pad             = '0;
        req_pad[CNT-1:0]    = req;
        last_pad            = '0;
        last_pad[CNT-1:0]   = last;
        cur_req             = req_pad[gnt_idx];
        cur_last            = last_pad[gnt_idx];
        beat                = gnt_vld & ready & cur_req;
        at_max              = (beat_cnt == BW'(MAX_BEATS - 1));
        drop_ev             = gnt_vld & ~cur_req;
        done_ev             = beat & cur_last;
        to_ev               = beat & at_max & ~cur_last;
        rel                 = drop_ev | done_ev | to_ev;
        nxt                 = 32'(gnt_idx) + 1;
        if (nxt >= CNT) nxt = 0;
        rel_ptr             = IW'(nxt);
    end

    // Rotating priority scan; on release the scan starts just past the
    // released requester, which therefore sits at lowest priority.
    always_comb begin
        int unsigned sb;
        int unsigned j;
        scan_base = gnt_vld ? rel_ptr : ptr;
        sb        = 32'(scan_base);
        found     = 1'b0;
        win       = '0;
        j         = 0;
        for (int unsigned i = 0; i < CNT; i++) begin
            j = sb + i;
            if (j >= CNT) j = j - CNT;
            if (!found && req_pad[IW'(j)]) begin
                found = 1'b1;
                win   = IW'(j);
            end
        end
        win_oh = CNT'(found) << win;
    end

    // Grant FSM with registered outputs and one-cycle error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            gnt_vld     <= 1'b0;
            gnt_idx     <= '0;
            ptr         <= '0;
            beat_cnt    <= '0;
            err_drop    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_drop    <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= BUSY;
                        gnt      <= win_oh;
                        gnt_vld  <= 1'b1;
                        gnt_idx  <= win;
                        beat_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (rel) begin
                        err_drop    <= drop_ev;
                        err_timeout <= to_ev & ~drop_ev;
                        ptr         <= rel_ptr;
                        beat_cnt    <= '0;
                        if (found) begin
                            gnt     <= win_oh;
                            gnt_idx <= win;
                        end else begin
                            state   <= IDLE;
                            gnt     <= '0;
                            gnt_vld <= 1'b0;
                            gnt_idx <= '0;
                        end
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_burst_arb.sv
// Bench for rr_burst_arb: directed scenarios followed by sticky random
// requests, all checked every cycle against a grant/pointer/beat-count model.
module tb_rr_burst_arb;

    localparam int CNT = 5;
    localparam int MB  = 4;

    logic           clk;
    logic           rst_n;
    logic [CNT-1:0] req;
    logic [CNT-1:0] last;
    logic           ready;
    logic [CNT-1:0] gnt;
    logic           gnt_vld;
    logic [2:0]     gnt_idx;
    logic           beat;
    logic           err_drop;
    logic           err_timeout;

    int n_cmp;
    int n_err;

    // model state
    bit m_vld;
    int m_idx;
    int m_ptr;
    int m_cnt;
    bit m_edrop;
    bit m_eto;

    rr_burst_arb #(.CNT(CNT), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last), .ready(ready),
        .gnt(gnt), .gnt_vld(gnt_vld), .gnt_idx(gnt_idx), .beat(beat),
        .err_drop(err_drop), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_vld = 0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_edrop = 0; m_eto = 0;
    endtask

    // first requesting index at or after p, wrapping around
    task automatic pick(input int p, output bit f, output int w);
        f = 0; w = 0;
        for (int k = 0; k < CNT; k++) begin
            if (!f && req[(p + k) % CNT]) begin
                f = 1; w = (p + k) % CNT;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".gnt"},     32'(gnt),         m_vld ? (32'd1 << m_idx) : 32'd0);
        chk({tag, ".vld"},     32'(gnt_vld),     32'(m_vld));
        chk({tag, ".idx"},     32'(gnt_idx),     m_vld ? 32'(m_idx) : 32'd0);
        chk({tag, ".beat"},    32'(beat),        32'(m_vld && ready && req[m_idx]));
        chk({tag, ".edrop"},   32'(err_drop),    32'(m_edrop));
        chk({tag, ".etime"},   32'(err_timeout), 32'(m_eto));
    endtask

    task automatic model_step();
        bit f; int w; bit dr; bit bt; bit ls;
        m_edrop = 0; m_eto = 0;
        if (!m_vld) begin
            pick(m_ptr, f, w);
            if (f) begin m_vld = 1; m_idx = w; m_cnt = 0; end
        end else begin
            dr = !req[m_idx];
            bt = ready && req[m_idx];
            ls = last[m_idx];
            if (dr || (bt && ls) || (bt && m_cnt == MB - 1)) begin
                m_edrop = dr;
                m_eto   = !dr && bt && !ls;
                m_ptr   = (m_idx + 1) % CNT;
                m_cnt   = 0;
                pick(m_ptr, f, w);
                if (f) m_idx = w;
                else begin m_vld = 0; m_idx = 0; end
            end else if (bt) begin
                m_cnt++;
            end
        end
    endtask

    // one clock: apply inputs at negedge, check, advance model and DUT
    task automatic drive(input logic [CNT-1:0] r, input logic [CNT-1:0] l, input logic rd);
        req = r; last = l; ready = rd;
        #1;
        check_outputs("cyc");
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [CNT-1:0] rr;
        n_cmp = 0; n_err = 0;
        req = '0; last = '0; ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // two requesters, three-beat burst, then no-bubble hand-over to 4
        drive(5'b10100, 5'b00000, 1'b1);
        chk("r31.first", 32'(gnt), 32'b00100);
        drive(5'b10100, 5'b00000, 1'b1);
        drive(5'b10100, 5'b00000, 1'b1);
        drive(5'b10100, 5'b00100, 1'b1);
        chk("r31.next", 32'(gnt), 32'b10000);
        drive(5'b10000, 5'b10000, 1'b1);

        // everyone requesting with single-beat bursts: strict rotation
        for (int k = 0; k < 6; k++) begin
            drive(5'b11111, 5'b11111, 1'b1);
            chk("r32.rot", 32'(gnt_idx), 32'(k % 5));
        end
        drive(5'b00000, 5'b00000, 1'b0);
        drive(5'b00000, 5'b00000, 1'b0);

        // sole requester 2, repeated one-beat bursts keep the grant
        for (int k = 0; k < 4; k++) begin
            drive(5'b00100, 5'b00100, 1'b1);
            chk("r33.hold", 32'(gnt), 32'b00100);
        end
        drive(5'b00000, 5'b00000, 1'b0);
        drive(5'b00000, 5'b00000, 1'b0);

        // requester 1 never signals last: forced release after MB beats
        for (int k = 0; k < 2 * MB + 2; k++) drive(5'b00010, 5'b00000, 1'b1);
        drive(5'b00000, 5'b00000, 1'b0);
        drive(5'b00000, 5'b00000, 1'b0);

        // requester 3 drops without last while stalled
        drive(5'b01000, 5'b00000, 1'b0);
        drive(5'b01000, 5'b00000, 1'b0);
        drive(5'b00001, 5'b00000, 1'b0);
        chk("r35.edrop", 32'(err_drop), 32'd1);
        chk("r35.etime", 32'(err_timeout), 32'd0);
        chk("r35.gnt", 32'(gnt), 32'b00001);
        drive(5'b00001, 5'b00001, 1'b1);
        drive(5'b00000, 5'b00000, 1'b0);

        // asynchronous reset in the middle of a burst
        drive(5'b00100, 5'b00000, 1'b1);
        drive(5'b00100, 5'b00000, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("r36.async");
        @(negedge clk);
        rst_n = 1'b1;
        drive(5'b00010, 5'b00000, 1'b1);
        chk("r36.after", 32'(gnt), 32'b00010);
        drive(5'b00010, 5'b00010, 1'b1);

        // sticky random requests
        rr = '0;
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < CNT; b++)
                if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
            drive(rr, CNT'($urandom) & CNT'($urandom), ($urandom_range(0, 3) != 0));
        end
        drive(5'b00000, 5'b00000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
